// File: rtl/axi4lite_pkg.sv
// rtl/axi4lite_pkg.sv - shared response codes, master states and protection default
package axi4lite_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_RESP,
    RD_ADDR,
    RD_DATA,
    DONE
  } mst_state_t;

  localparam logic [2:0] PROT_DEFAULT = 3'b000;

endpackage

// File: rtl/axi4lite_watchdog.sv
// rtl/axi4lite_watchdog.sv - cycle watchdog: counts while enabled, pulses expire at limit-1
module axi4lite_watchdog #(
  parameter int CNT_W = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             clear,
  input  logic [CNT_W-1:0] limit,
  output logic             expire
);

  logic [CNT_W-1:0] cnt_q;

  assign expire = enable && (cnt_q == (limit - CNT_W'(1)));

  // Count busy cycles; the owner drops enable once expire has been acted on
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/axi4lite_master_initiator.sv
// rtl/axi4lite_master_initiator.sv - AXI4-lite single-beat master; watchdog under AXI4LITE_MASTER_TIMEOUT_EN
module axi4lite_master_initiator
  import axi4lite_pkg::*;
#(
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_M_AXI_ADDR_WIDTH = 11,
  parameter int TIMEOUT_CYCLES     = 1024
) (
  input  logic                            axi_clk,
  input  logic                            axi_rst,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic                            cmd_write,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                            rsp_valid,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]                      rsp_resp,
  output logic                            rsp_timeout,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]                      M_AXI_AWPROT,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]                      M_AXI_ARPROT,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY
);

  localparam int DW = C_M_AXI_DATA_WIDTH;
  localparam int AW = C_M_AXI_ADDR_WIDTH;
  localparam int SW = C_M_AXI_DATA_WIDTH / 8;

  mst_state_t    state_q, state_d;
  logic          aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic          cmd_ready_q, awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q, rsp_valid_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q, rdata_q;
  logic [SW-1:0] wstrb_q;
  logic [1:0]    resp_q;
  logic          accept, aw_hs, w_hs, b_hs, ar_hs, r_hs, expire;

  assign accept = (state_q == IDLE) && cmd_ready_q && cmd_valid;
  assign aw_hs  = awvalid_q && M_AXI_AWREADY;
  assign w_hs   = wvalid_q && M_AXI_WREADY;
  assign b_hs   = bready_q && M_AXI_BVALID;
  assign ar_hs  = arvalid_q && M_AXI_ARREADY;
  assign r_hs   = rready_q && M_AXI_RVALID;

`ifdef AXI4LITE_MASTER_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic rsp_timeout_q;

  axi4lite_watchdog #(.CNT_W(WD_W)) u_watchdog (
    .clk    (axi_clk),
    .rst    (axi_rst),
    .enable ((state_q != IDLE) && (state_q != DONE)),
    .clear  (state_q == IDLE),
    .limit  (WD_W'(TIMEOUT_CYCLES)),
    .expire (expire)
  );

  // Mark the response of a transaction the watchdog abandoned
  always_ff @(posedge axi_clk or posedge axi_rst) begin
    if (axi_rst) begin
      rsp_timeout_q <= 1'b0;
    end else if (expire) begin
      rsp_timeout_q <= 1'b1;
    end else if (accept) begin
      rsp_timeout_q <= 1'b0;
    end
  end

  assign rsp_timeout = rsp_timeout_q;
`else
  assign expire      = 1'b0;
  assign rsp_timeout = 1'b0;
`endif

  // State register and per-channel write handshake flags
  always_ff @(posedge axi_clk or posedge axi_rst) begin
    if (axi_rst) begin
      state_q   <= IDLE;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  // Next state; AW and W retire independently and either order is accepted
  always_comb begin
    state_d   = state_q;
    aw_done_d = 1'b0;
    w_done_d  = 1'b0;
    case (state_q)
      IDLE:    if (accept) state_d = cmd_write ? WR_REQ : RD_ADDR;
      WR_REQ: begin
        aw_done_d = aw_done_q || aw_hs;
        w_done_d  = w_done_q || w_hs;
        if (aw_done_d && w_done_d) state_d = WR_RESP;
      end
      WR_RESP: if (b_hs) state_d = DONE;
      RD_ADDR: if (ar_hs) state_d = RD_DATA;
      RD_DATA: if (r_hs) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (expire) state_d = DONE;
  end

  // Handshake outputs registered from the next state so no VALID follows a READY combinationally
  always_ff @(posedge axi_clk or posedge axi_rst) begin
    if (axi_rst) begin
      cmd_ready_q <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      cmd_ready_q <= (state_d == IDLE);
      awvalid_q   <= (state_d == WR_REQ) && !aw_done_d;
      wvalid_q    <= (state_d == WR_REQ) && !w_done_d;
      bready_q    <= (state_d == WR_RESP);
      arvalid_q   <= (state_d == RD_ADDR);
      rready_q    <= (state_d == RD_DATA);
      rsp_valid_q <= (state_d == DONE);
    end
  end

  // Command payload held for the whole transaction so AXI payload stays stable under VALID
  always_ff @(posedge axi_clk or posedge axi_rst) begin
    if (axi_rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else if (accept) begin
      addr_q  <= cmd_addr;
      wdata_q <= cmd_wdata;
      wstrb_q <= cmd_wstrb;
    end
  end

  // Response capture; slave error codes pass through untouched
  always_ff @(posedge axi_clk or posedge axi_rst) begin
    if (axi_rst) begin
      rdata_q <= '0;
      resp_q  <= OKAY;
    end else if (expire) begin
      rdata_q <= '0;
      resp_q  <= SLVERR;
    end else if (b_hs) begin
      rdata_q <= '0;
      resp_q  <= M_AXI_BRESP;
    end else if (r_hs) begin
      rdata_q <= M_AXI_RDATA;
      resp_q  <= M_AXI_RRESP;
    end
  end

  assign cmd_ready     = cmd_ready_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rdata_q;
  assign rsp_resp      = resp_q;
  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_AWPROT  = PROT_DEFAULT;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = wstrb_q;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_BREADY  = bready_q;
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_ARPROT  = PROT_DEFAULT;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_axi4lite_master_initiator.sv
// tb/tb_axi4lite_master_initiator.sv - directed scoreboard bench for axi4lite_master_initiator
module tb_axi4lite_master_initiator;

`ifdef AXI4LITE_MASTER_TIMEOUT_EN
  localparam int TB_TO = 16;
`else
  localparam int TB_TO = 1024;
`endif

  typedef struct packed {
    logic        to;
    logic [1:0]  resp;
    logic [31:0] rdata;
  } exp_t;

  logic        axi_clk = 1'b0;
  logic        axi_rst = 1'b1;
  logic        cmd_valid = 1'b0, cmd_write = 1'b0;
  logic [10:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic [3:0]  cmd_wstrb = '0;
  logic        cmd_ready, rsp_valid, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [10:0] awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, wvalid, bready, arvalid, rready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;

  int checks = 0, failures = 0;
  int cyc = 0, acc_cyc = 0, prev_acc = 0, last_rsp_cyc = 0, rsp_n = 0;
  exp_t sb[$];

  int aw_dly = 0, w_dly = 0, ar_dly = 0;
  bit b_en = 1'b1, ar_en = 1'b1;
  logic [1:0] b_resp_k = 2'b00, r_resp_k = 2'b00;
  int b_hs_n = 0, arv_n = 0, ar_unstable = 0, aw_hs_cyc = 0, w_hs_cyc = 0;
  logic [31:0] mem [512];

  axi4lite_master_initiator #(
    .C_M_AXI_DATA_WIDTH (32),
    .C_M_AXI_ADDR_WIDTH (11),
    .TIMEOUT_CYCLES     (TB_TO)
  ) dut (
    .axi_clk       (axi_clk),
    .axi_rst       (axi_rst),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_write     (cmd_write),
    .cmd_addr      (cmd_addr),
    .cmd_wdata     (cmd_wdata),
    .cmd_wstrb     (cmd_wstrb),
    .rsp_valid     (rsp_valid),
    .rsp_rdata     (rsp_rdata),
    .rsp_resp      (rsp_resp),
    .rsp_timeout   (rsp_timeout),
    .M_AXI_AWADDR  (awaddr),
    .M_AXI_AWPROT  (awprot),
    .M_AXI_AWVALID (awvalid),
    .M_AXI_AWREADY (awready),
    .M_AXI_WDATA   (wdata),
    .M_AXI_WSTRB   (wstrb),
    .M_AXI_WVALID  (wvalid),
    .M_AXI_WREADY  (wready),
    .M_AXI_BRESP   (bresp),
    .M_AXI_BVALID  (bvalid),
    .M_AXI_BREADY  (bready),
    .M_AXI_ARADDR  (araddr),
    .M_AXI_ARPROT  (arprot),
    .M_AXI_ARVALID (arvalid),
    .M_AXI_ARREADY (arready),
    .M_AXI_RDATA   (rdata),
    .M_AXI_RRESP   (rresp),
    .M_AXI_RVALID  (rvalid),
    .M_AXI_RREADY  (rready)
  );

  initial forever #5 axi_clk = ~axi_clk;
  initial forever begin @(posedge axi_clk); cyc++; end

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Slave model: configurable ready delays, byte-strobed register file, forced response codes
  initial begin
    logic s_aw, s_w, s_b, s_ar, s_r, aw_got, w_got;
    logic [10:0] aw_a, ar_a, ar_seen;
    logic [31:0] w_d;
    logic [3:0]  w_s;
    int aw_c, w_c, ar_c;
    aw_got = 0; w_got = 0; aw_a = 0; ar_a = 0; ar_seen = 0; w_d = 0; w_s = 0;
    aw_c = 0; w_c = 0; ar_c = 0;
    awready = 0; wready = 0; bvalid = 0; bresp = 0; arready = 0; rvalid = 0; rresp = 0; rdata = 0;
    for (int i = 0; i < 512; i++) mem[i] = 32'h0;
    mem[1]   = 32'h0000_0001;
    mem[511] = 32'hCAFE_F00D;
    forever begin
      @(negedge axi_clk);
      s_aw = awvalid && awready;
      s_w  = wvalid && wready;
      s_b  = bvalid && bready;
      s_ar = arvalid && arready;
      s_r  = rvalid && rready;
      if (arvalid) begin
        arv_n++;
        if (arv_n > 1 && araddr != ar_seen) ar_unstable++;
        ar_seen = araddr;
      end
      if (s_aw) begin aw_got = 1; aw_a = awaddr; aw_hs_cyc = cyc; end
      if (s_w) begin w_got = 1; w_d = wdata; w_s = wstrb; w_hs_cyc = cyc; end
      if (s_b) b_hs_n++;
      if (s_ar) ar_a = araddr;
      @(posedge axi_clk);
      #1;
      if (axi_rst) begin
        awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
        aw_got = 0; w_got = 0; aw_c = 0; w_c = 0; ar_c = 0;
        continue;
      end
      if (s_aw || !awvalid) begin awready = 0; aw_c = 0; end
      else begin awready = (aw_c >= aw_dly); aw_c++; end
      if (s_w || !wvalid) begin wready = 0; w_c = 0; end
      else begin wready = (w_c >= w_dly); w_c++; end
      if (s_ar || !arvalid) begin arready = 0; ar_c = 0; end
      else begin arready = ar_en && (ar_c >= ar_dly); ar_c++; end
      if (s_b) bvalid = 0;
      if (aw_got && w_got && b_en && !bvalid) begin
        for (int k = 0; k < 4; k++)
          if (w_s[k]) mem[aw_a[10:2]][8*k +: 8] = w_d[8*k +: 8];
        bvalid = 1; bresp = b_resp_k; aw_got = 0; w_got = 0;
      end
      if (s_r) rvalid = 0;
      if (s_ar) begin rvalid = 1; rdata = mem[ar_a[10:2]]; rresp = r_resp_k; end
    end
  end

  // Response monitor: every rsp_valid cycle must match the oldest outstanding expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge axi_clk);
      if (!axi_rst && rsp_valid) begin
        rsp_n++;
        last_rsp_cyc = cyc;
        chk("rsp_expected", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("rsp_rdata", rsp_rdata, e.rdata);
          chk("rsp_resp", rsp_resp, e.resp);
          chk("rsp_timeout", rsp_timeout, e.to);
        end
      end
    end
  end

  task automatic issue(input logic wr, input logic [10:0] a, input logic [31:0] d, input logic [3:0] s,
                       input logic [31:0] er, input logic [1:0] eresp, input logic eto);
    int n;
    exp_t e;
    n = 0;
    @(posedge axi_clk);
    #1;
    cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    @(negedge axi_clk);
    while (!cmd_ready && n < 20) begin @(negedge axi_clk); n++; end
    chk("cmd_accept", cmd_ready, 1);
    prev_acc = acc_cyc;
    acc_cyc = cyc;
    e.to = eto; e.resp = eresp; e.rdata = er;
    sb.push_back(e);
    @(posedge axi_clk);
    #1;
    cmd_valid = 0;
    cmd_addr = 11'($urandom); cmd_wdata = $urandom; cmd_wstrb = 4'($urandom); cmd_write = 1'($urandom);
  endtask

  task automatic wait_rsp(input int prev);
    int n;
    n = 0;
    while (rsp_n == prev && n < 100) begin @(negedge axi_clk); #1; n++; end
    chk("rsp_seen", rsp_n == prev + 1, 1);
  endtask

  initial begin
    int p, b0, n;
    // Reset values
    repeat (2) @(posedge axi_clk);
    @(negedge axi_clk);
    chk("reset_handshakes", {cmd_ready, awvalid, wvalid, bready, arvalid, rready, rsp_valid}, 7'b0);
    chk("reset_addr", {awaddr, araddr}, 22'h0);
    chk("reset_rsp", {rsp_rdata, rsp_resp, rsp_timeout}, 35'h0);
    chk("prot", {awprot, arprot}, 6'b0);
    @(posedge axi_clk); #1; axi_rst = 0;
    @(posedge axi_clk); #1;
    chk("ready_after_reset", cmd_ready, 1);

    // Zero-wait write, then read back
    p = rsp_n; issue(1, 11'h000, 32'h0000_0010, 4'hF, 32'h0, 2'b00, 0); wait_rsp(p);
    chk("wr_latency", last_rsp_cyc - acc_cyc + 1, 4);
    chk("aw_cycle", aw_hs_cyc - acc_cyc, 1);
    chk("w_cycle", w_hs_cyc - acc_cyc, 1);
    p = rsp_n; issue(0, 11'h000, 32'h0, 4'h0, 32'h0000_0010, 2'b00, 0); wait_rsp(p);
    chk("rd_latency", last_rsp_cyc - acc_cyc + 1, 4);
    chk("b2b_spacing", acc_cyc - prev_acc, 4);

    // Partial strobe write and readback
    p = rsp_n; issue(1, 11'h008, 32'hAABB_CCDD, 4'b0101, 32'h0, 2'b00, 0); wait_rsp(p);
    p = rsp_n; issue(0, 11'h008, 32'h0, 4'h0, 32'h00BB_00DD, 2'b00, 0); wait_rsp(p);

    // Read with ARREADY delayed 3 cycles
    ar_dly = 3; arv_n = 0; ar_unstable = 0;
    p = rsp_n; issue(0, 11'h004, 32'h0, 4'h0, 32'h0000_0001, 2'b00, 0); wait_rsp(p);
    chk("arvalid_cycles", arv_n, 4);
    chk("araddr_stable", ar_unstable, 0);
    chk("rd_delay_latency", last_rsp_cyc - acc_cyc + 1, 7);
    ar_dly = 0;

    // W completes before AW
    aw_dly = 2; w_dly = 0; b0 = b_hs_n;
    p = rsp_n; issue(1, 11'h010, 32'h1234_5678, 4'hF, 32'h0, 2'b00, 0);
    @(negedge axi_clk); @(negedge axi_clk);
    chk("w_first_valids", {awvalid, wvalid}, 2'b10);
    wait_rsp(p);
    chk("w_first_b_count", b_hs_n - b0, 1);

    // AW completes before W
    aw_dly = 0; w_dly = 2; b0 = b_hs_n;
    p = rsp_n; issue(1, 11'h014, 32'h8765_4321, 4'hF, 32'h0, 2'b00, 0);
    @(negedge axi_clk); @(negedge axi_clk);
    chk("aw_first_valids", {awvalid, wvalid}, 2'b01);
    wait_rsp(p);
    chk("aw_first_b_count", b_hs_n - b0, 1);
    w_dly = 0;

    // DECERR read, then a SLVERR write accepted right after
    r_resp_k = 2'b11;
    p = rsp_n; issue(0, 11'h7FC, 32'h0, 4'h0, 32'hCAFE_F00D, 2'b11, 0); wait_rsp(p);
    r_resp_k = 2'b00; b_resp_k = 2'b10;
    p = rsp_n; issue(1, 11'h00C, 32'h0000_0005, 4'hF, 32'h0, 2'b10, 0); wait_rsp(p);
    chk("after_err_spacing", acc_cyc - prev_acc, 4);
    b_resp_k = 2'b00;

    // Reset while waiting in WR_RESP
    b_en = 0; n = 0;
    p = rsp_n; issue(1, 11'h020, 32'hDEAD_0001, 4'hF, 32'h0, 2'b00, 0);
    @(negedge axi_clk);
    while (!bready && n < 20) begin @(negedge axi_clk); n++; end
    chk("reached_wr_resp", bready, 1);
    #1; axi_rst = 1; #1;
    chk("rst_mid_outputs", {cmd_ready, awvalid, wvalid, bready, arvalid, rready, rsp_valid}, 7'b0);
    sb.delete();
    @(posedge axi_clk); @(posedge axi_clk); #1; axi_rst = 0;
    @(posedge axi_clk); @(negedge axi_clk);
    chk("ready_after_mid_reset", cmd_ready, 1);
    chk("no_rsp_after_reset", rsp_n, p);
    b_en = 1;

`ifdef AXI4LITE_MASTER_TIMEOUT_EN
    // Slave never accepts AR: watchdog ends the transaction
    ar_en = 0; arv_n = 0;
    p = rsp_n; issue(0, 11'h030, 32'h0, 4'h0, 32'h0, 2'b10, 1); wait_rsp(p);
    chk("timeout_arvalid_cycles", arv_n, 16);
    ar_en = 1;
`endif

    // Normal traffic resumes after the reset
    p = rsp_n; issue(0, 11'h7FC, 32'h0, 4'h0, 32'hCAFE_F00D, 2'b00, 0); wait_rsp(p);

    repeat (3) @(posedge axi_clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axi4lite_master_initiator.md
Name: axi4lite_master_initiator

Overview:
- AXI4-lite master that issues single-beat register writes and reads on behalf of on-fabric logic. It is the initiator-side counterpart of the team's axi4lite_interface_top slave.
- Lets firmware blocks program other AXI-mapped blocks (e.g. clock-divider registers) without a processor.
- Simple valid/ready command port in; one response per command out.

Parameters:
- C_M_AXI_DATA_WIDTH, 32, AXI data width; must be a multiple of 8.
- C_M_AXI_ADDR_WIDTH, 11, AXI address width.
- TIMEOUT_CYCLES, 1024, watchdog limit in cycles; used only with the optional feature.

Ports:
- axi_clk  in  1  single clock for all logic.
- axi_rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  byte address.
- cmd_wdata  in  DATA_W  write data.
- cmd_wstrb  in  DATA_W/8  write strobes.
- rsp_valid  out  1  response pulse, exactly 1 cycle.
- rsp_rdata  out  DATA_W  read data; 0 for writes.
- rsp_resp  out  2  BRESP/RRESP value.
- rsp_timeout  out  1  watchdog fired (feature only, else tied 0).
- M_AXI_AWADDR, AWPROT, AWVALID, AWREADY, WDATA, WSTRB, WVALID, WREADY, BRESP, BVALID, BREADY, ARADDR, ARPROT, ARVALID, ARREADY, RDATA, RRESP, RVALID, RREADY: standard AXI4-lite master directions and widths.

Behaviour:
- Reset (async assert, sync release to axi_clk):
  - state=IDLE; all VALID/READY outputs 0; rsp_* = 0; address/data registers = 0.
  - AWPROT = ARPROT = 3'b000 at all times.
- IDLE: cmd_ready=1. On cmd_valid, latch addr/wdata/wstrb.
  - Write goes to WR_REQ with AWVALID=1 and WVALID=1 on the next cycle.
  - Read goes to RD_ADDR with ARVALID=1.
- WR_REQ:
  - AW and W complete independently. AWVALID drops the cycle after AWVALID&&AWREADY; WVALID drops the cycle after WVALID&&WREADY.
  - Internal aw_done/w_done flags track each handshake. Both in the same cycle is legal.
  - When both are done, go to WR_RESP.
- WR_RESP: BREADY=1. On BVALID, capture BRESP and go to DONE.
- RD_ADDR: hold ARVALID and ARADDR stable until ARREADY, then go to RD_DATA.
- RD_DATA: RREADY=1. On RVALID, capture RDATA and RRESP and go to DONE.
- DONE: rsp_valid=1 for one cycle, then IDLE.
  - Minimum command-to-command spacing is 4 cycles (slave ready same cycle).
  - Back-to-back cmd_valid is accepted on the IDLE cycle following DONE.
- Latency, zero-wait slave:
  - write: cmd accept, then AW/W beat, then B, then rsp = 4 cycles.
  - read: cmd accept, then AR, then R, then rsp = 4 cycles.
- AXI rules:
  - VALID never depends combinationally on READY.
  - Payload is stable while VALID is high.
- Command-port rules:
  - cmd fields are ignored outside IDLE.
  - A slave BRESP/RRESP of SLVERR or DECERR is forwarded unchanged; no retry.
- Reset mid-transaction: abandon immediately, all VALIDs to 0, no rsp_valid.

Optional Feature:
- Macro AXI4LITE_MASTER_TIMEOUT_EN.
- Enabled:
  - A watchdog counts cycles in any non-IDLE/non-DONE state and clears on entering IDLE.
  - When the count reaches TIMEOUT_CYCLES-1, force all VALID/READY low and go to DONE.
  - The response carries rsp_timeout=1, rsp_resp=2'b10 and rsp_rdata=0.
- Disabled: no counter; the block waits indefinitely; rsp_timeout tied 0.

Decomposition:
- Package axi4lite_pkg:
  - resp_t enum OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11.
  - mst_state_t enum IDLE, WR_REQ, WR_RESP, RD_ADDR, RD_DATA, DONE.
  - PROT_DEFAULT=3'b000.
- Sub-module axi4lite_watchdog: enable/clear/limit to expire pulse. Instantiated only under the macro.

Test Plan:
- Write 0x0000_0010 to addr 0x000, strobe 4'hF, zero-wait slave: AW and W in the same cycle; rsp_valid 4 cycles after accept; rsp_resp=0; slave register reads back 0x10.
- Read addr 0x004 with slave returning 0x0000_0001 and ARREADY delayed 3 cycles: ARVALID held 4 cycles with ARADDR stable; rsp_rdata=0x1; latency 7 cycles.
- Write with WREADY 2 cycles before AWREADY (and the reverse): WVALID drops first, and AWVALID drops first in the reverse case; exactly one B accepted; one rsp_valid.
- Slave returns RRESP=DECERR on read 0x7FC: rsp_resp=2'b11; rsp_rdata equals RDATA; next command accepted in IDLE.
- axi_rst asserted while in WR_RESP with BVALID=0: all outputs 0 within the same cycle; no rsp_valid; cmd_ready=1 after release.
- With AXI4LITE_MASTER_TIMEOUT_EN and TIMEOUT_CYCLES=16, slave never asserts ARREADY: ARVALID drops after 16 cycles; rsp_timeout=1; rsp_resp=2'b10.
